// File: rtl/cnn_ctrl_pkg.sv
// Shared types and limits for the CNN layer controllers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_ctrl_pkg;

  // Largest legal stride exponent; 3 is reserved and rejected at start.
  localparam int STRIDE_LOG2_MAX = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONFIG = 3'd1,
    CLEAR  = 3'd2,
    RUN    = 3'd3,
    NEXT   = 3'd4,
    DONE   = 3'd5
  } sched_state_e;

endpackage

// File: rtl/conv_osize_calc.sv
// Output side length of a convolution, ((i_size-k_size)>>stride_log2)+1, with a geometry validity flag.
// Latency: combinational.
// Backpressure: none.
// Ports: i_i_size/i_k_size/i_stride_log2 geometry in; o_o_size result; o_valid geometry legal.
module conv_osize_calc
  import cnn_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-1:0] i_i_size,
  input  logic [ADDR_WIDTH-1:0] i_k_size,
  input  logic [1:0]            i_stride_log2,
  output logic [ADDR_WIDTH-1:0] o_o_size,
  output logic                  o_valid
);

  logic [ADDR_WIDTH-1:0] diff;

  assign diff     = i_i_size - i_k_size;
  assign o_o_size = (diff >> i_stride_log2) + ADDR_WIDTH'(1);
  // Kernel must be non-empty and fit inside the input; num_ch is checked by the caller.
  assign o_valid  = (i_k_size != '0) && (i_k_size <= i_i_size) &&
                    (i_stride_log2 <= 2'(STRIDE_LOG2_MAX));

endmodule

// File: rtl/conv_pass_scheduler.sv
// Sequences one coordinate_generator over every input channel of a convolution pass.
// Latency: first o_cg_en in the 3rd cycle after the edge accepting i_start; 2 + 4 cycles per channel minimum.
// Backpressure: none; each channel waits on i_cg_done, i_abort drops the pass the next cycle.
// Ports: i_clk/i_rst, pass config + i_start/i_abort in, o_cg_* generator program/control out,
//        i_cg_done from generator, o_busy/o_done/o_err/o_ch_idx/o_cycle_cnt status out.
// Build option: define CONV_PASS_SCHED_PERF_EN for the saturating busy-cycle counter on o_cycle_cnt.
module conv_pass_scheduler
  import cnn_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int CH_WIDTH   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_i_size,
  input  logic [ADDR_WIDTH-1:0] i_k_size,
  input  logic [1:0]            i_stride_log2,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [CH_WIDTH-1:0]   i_num_ch,
  output logic                  o_cg_en,
  output logic                  o_cg_reg_clear,
  output logic [ADDR_WIDTH-1:0] o_cg_i_size,
  output logic [ADDR_WIDTH-1:0] o_cg_o_size,
  output logic [ADDR_WIDTH-1:0] o_cg_stride,
  output logic [ADDR_WIDTH-1:0] o_cg_start_addr,
  input  logic                  i_cg_done,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [CH_WIDTH-1:0]   o_ch_idx,
  output logic [31:0]           o_cycle_cnt
);

  sched_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]   cfg_i_size_q, cfg_k_size_q, cfg_base_q;
  logic [1:0]              cfg_stride_q;
  logic [CH_WIDTH-1:0]     cfg_num_ch_q;
  logic [ADDR_WIDTH-1:0]   cg_i_size_q, cg_o_size_q, cg_stride_q, cg_addr_q;
  logic [CH_WIDTH-1:0]     ch_idx_q;
  logic                    en_q, clr_q, busy_q, done_q, err_q;
  logic                    run_armed_q;

  logic                    is_idle;
  logic [ADDR_WIDTH-1:0]   calc_i_size, calc_k_size, calc_o_size;
  logic [1:0]              calc_stride;
  logic                    calc_valid, cfg_ok, start_acc, last_ch;
  logic [2*ADDR_WIDTH-1:0] plane_sq;

  assign is_idle = (state_q == IDLE);

  // In IDLE the calculator validates the live inputs; afterwards it works on the latched copy.
  assign calc_i_size = is_idle ? i_i_size      : cfg_i_size_q;
  assign calc_k_size = is_idle ? i_k_size      : cfg_k_size_q;
  assign calc_stride = is_idle ? i_stride_log2 : cfg_stride_q;

  conv_osize_calc #(.ADDR_WIDTH(ADDR_WIDTH)) u_osize (
    .i_i_size      (calc_i_size),
    .i_k_size      (calc_k_size),
    .i_stride_log2 (calc_stride),
    .o_o_size      (calc_o_size),
    .o_valid       (calc_valid)
  );

  assign cfg_ok    = calc_valid && (i_num_ch != '0);
  assign start_acc = is_idle && i_start && !i_abort;
  assign last_ch   = (ch_idx_q == cfg_num_ch_q - CH_WIDTH'(1));
  assign plane_sq  = cfg_i_size_q * cfg_i_size_q;

  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (i_start && cfg_ok) state_d = CONFIG;
        CONFIG:  state_d = CLEAR;
        CLEAR:   state_d = RUN;
        // A done left over from the previous channel is ignored in the first RUN cycle.
        RUN:     if (run_armed_q && i_cg_done) state_d = NEXT;
        NEXT:    state_d = last_ch ? DONE : CLEAR;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cfg_i_size_q <= '0;
      cfg_k_size_q <= '0;
      cfg_stride_q <= '0;
      cfg_base_q   <= '0;
      cfg_num_ch_q <= '0;
      cg_i_size_q  <= '0;
      cg_o_size_q  <= '0;
      cg_stride_q  <= '0;
      cg_addr_q    <= '0;
      ch_idx_q     <= '0;
      en_q         <= 1'b0;
      clr_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      run_armed_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Moore outputs registered off the next state so they line up with state_q.
      en_q        <= (state_d == RUN);
      clr_q       <= (state_d == CLEAR);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      err_q       <= start_acc && !cfg_ok;
      run_armed_q <= (state_q == RUN);

      if (start_acc) begin
        cfg_i_size_q <= i_i_size;
        cfg_k_size_q <= i_k_size;
        cfg_stride_q <= i_stride_log2;
        cfg_base_q   <= i_base_addr;
        cfg_num_ch_q <= i_num_ch;
      end

      if (state_q == CONFIG) begin
        cg_i_size_q <= cfg_i_size_q;
        cg_o_size_q <= calc_o_size;
        cg_stride_q <= ADDR_WIDTH'(1) << cfg_stride_q;
        cg_addr_q   <= cfg_base_q;
        ch_idx_q    <= '0;
      end

      if (state_q == NEXT && !i_abort && !last_ch) begin
        ch_idx_q  <= ch_idx_q + CH_WIDTH'(1);
        cg_addr_q <= cg_addr_q + plane_sq[ADDR_WIDTH-1:0];
      end
    end
  end

  assign o_cg_en         = en_q;
  assign o_cg_reg_clear  = clr_q;
  assign o_cg_i_size     = cg_i_size_q;
  assign o_cg_o_size     = cg_o_size_q;
  assign o_cg_stride     = cg_stride_q;
  assign o_cg_start_addr = cg_addr_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_err           = err_q;
  assign o_ch_idx        = ch_idx_q;

`ifdef CONV_PASS_SCHED_PERF_EN
  logic [31:0] cyc_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cyc_q <= '0;
    end else if (start_acc && cfg_ok) begin
      cyc_q <= '0;
    end else if (busy_q && (cyc_q != '1)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign o_cycle_cnt = cyc_q;
`else
  assign o_cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_pass_scheduler.sv
// Directed bench for conv_pass_scheduler: hand-computed expectations, assertion per comparison.
// Latency: n/a.
// Backpressure: n/a.
module tb_conv_pass_scheduler;

`ifdef CONV_PASS_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk, rst, start, abort, cg_done;
  logic [7:0] i_size, k_size, base, num_ch;
  logic [1:0] stride_log2;
  logic       cg_en, cg_clr, busy, done, err;
  logic [7:0] cg_i_size, cg_o_size, cg_stride, cg_addr, ch_idx;
  logic [31:0] cycle_cnt;

  int checks   = 0;
  int failures = 0;

  conv_pass_scheduler #(.ADDR_WIDTH(8), .CH_WIDTH(8)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_abort         (abort),
    .i_i_size        (i_size),
    .i_k_size        (k_size),
    .i_stride_log2   (stride_log2),
    .i_base_addr     (base),
    .i_num_ch        (num_ch),
    .o_cg_en         (cg_en),
    .o_cg_reg_clear  (cg_clr),
    .o_cg_i_size     (cg_i_size),
    .o_cg_o_size     (cg_o_size),
    .o_cg_stride     (cg_stride),
    .o_cg_start_addr (cg_addr),
    .i_cg_done       (cg_done),
    .o_busy          (busy),
    .o_done          (done),
    .o_err           (err),
    .o_ch_idx        (ch_idx),
    .o_cycle_cnt     (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [7:0] isz, input logic [7:0] k, input logic [1:0] s,
                             input logic [7:0] b, input logic [7:0] n);
    i_size = isz; k_size = k; stride_log2 = s; base = b; num_ch = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs a full pass, answering every enabled cycle with cg_done (so the first-cycle guard is exercised).
  task automatic run_pass(input logic [7:0] isz, input logic [7:0] k, input logic [1:0] s,
                          input logic [7:0] b, input logic [7:0] n,
                          input logic [7:0] exp_osize, input logic [7:0] exp_stride);
    int nclr = 0, ndone = 0, nbusy = 0;
    logic [7:0]  ea = b;
    logic [15:0] sq = isz * isz;
    drive_start(isz, k, s, b, n);
    check("pass_busy_start", {31'b0, busy}, 32'd1);
    nbusy = 1;
    for (int c = 0; c < 300; c++) begin
      cg_done = cg_en;
      tick();
      if (busy) nbusy++;
      if (done) ndone++;
      if (cg_clr) begin
        check("clr_addr", {24'b0, cg_addr}, {24'b0, ea});
        check("clr_ch_idx", {24'b0, ch_idx}, nclr);
        check("clr_osize", {24'b0, cg_o_size}, {24'b0, exp_osize});
        check("clr_stride", {24'b0, cg_stride}, {24'b0, exp_stride});
        check("clr_isize", {24'b0, cg_i_size}, {24'b0, isz});
        ea = ea + sq[7:0];
        nclr++;
      end
      if (!busy) break;
    end
    cg_done = 1'b0;
    check("pass_terminated", {31'b0, busy}, 32'd0);
    check("pass_clear_pulses", nclr, {24'b0, n});
    check("pass_done_pulses", ndone, 32'd1);
    check("pass_busy_cycles", nbusy, 32'd2 + 32'd4 * {24'b0, n});
    check("pass_cycle_cnt", cycle_cnt, PERF ? nbusy : 32'd0);
  endtask

  task automatic err_case(input string tag, input logic [7:0] isz, input logic [7:0] k,
                          input logic [1:0] s, input logic [7:0] n, input logic [7:0] keep_osize);
    drive_start(isz, k, s, 8'h55, n);
    check({tag, "_err"}, {31'b0, err}, 32'd1);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    tick();
    check({tag, "_err_pulse"}, {31'b0, err}, 32'd0);
    check({tag, "_busy2"}, {31'b0, busy}, 32'd0);
    check({tag, "_osize_kept"}, {24'b0, cg_o_size}, {24'b0, keep_osize});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cg_done = 1'b0;
    i_size = '0; k_size = '0; stride_log2 = '0; base = '0; num_ch = '0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_en", {31'b0, cg_en}, 32'd0);
    check("rst_clr", {31'b0, cg_clr}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_osize", {24'b0, cg_o_size}, 32'd0);
    check("rst_addr", {24'b0, cg_addr}, 32'd0);
    check("rst_ch_idx", {24'b0, ch_idx}, 32'd0);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single channel, stepped cycle by cycle: 5x5 input, 3x3 kernel, stride 1.
    drive_start(8'd5, 8'd3, 2'd0, 8'd0, 8'd1);
    check("t1_config_busy", {31'b0, busy}, 32'd1);
    check("t1_config_en", {31'b0, cg_en}, 32'd0);
    tick();
    check("t1_clear", {31'b0, cg_clr}, 32'd1);
    check("t1_clear_en", {31'b0, cg_en}, 32'd0);
    check("t1_osize", {24'b0, cg_o_size}, 32'd3);
    check("t1_stride", {24'b0, cg_stride}, 32'd1);
    check("t1_addr", {24'b0, cg_addr}, 32'd0);
    tick();
    check("t1_first_en", {31'b0, cg_en}, 32'd1);
    check("t1_clear_pulse", {31'b0, cg_clr}, 32'd0);
    cg_done = 1'b1;                 // stale done in the first RUN cycle
    tick();
    check("t1_stale_guard", {31'b0, cg_en}, 32'd1);
    tick();
    cg_done = 1'b0;
    check("t1_en_drop", {31'b0, cg_en}, 32'd0);
    check("t1_next_busy", {31'b0, busy}, 32'd1);
    check("t1_next_no_done", {31'b0, done}, 32'd0);
    tick();
    check("t1_done", {31'b0, done}, 32'd1);
    tick();
    check("t1_done_pulse", {31'b0, done}, 32'd0);
    check("t1_idle", {31'b0, busy}, 32'd0);
    check("t1_osize_hold", {24'b0, cg_o_size}, 32'd3);
    check("t1_cycle_cnt", cycle_cnt, PERF ? 32'd6 : 32'd0);

    // Multi-channel address stepping, stride 2, kernel==input boundary, address wrap.
    run_pass(8'd4, 8'd2, 2'd0, 8'h10, 8'd3, 8'd3, 8'd1);
    run_pass(8'd7, 8'd3, 2'd1, 8'h00, 8'd1, 8'd3, 8'd2);
    run_pass(8'd5, 8'd5, 2'd2, 8'h20, 8'd1, 8'd1, 8'd4);
    run_pass(8'd4, 8'd1, 2'd0, 8'hF0, 8'd2, 8'd4, 8'd1);

    // Rejected configurations leave the previous o_size (4) in place.
    err_case("err_k_gt_i", 8'd5, 8'd6, 2'd0, 8'd1, 8'd4);
    err_case("err_nch0", 8'd5, 8'd3, 2'd0, 8'd0, 8'd4);
    err_case("err_stride3", 8'd5, 8'd3, 2'd3, 8'd1, 8'd4);
    err_case("err_k0", 8'd5, 8'd0, 2'd0, 8'd1, 8'd4);

    // Abort in RUN of channel 1, with cg_done also high.
    drive_start(8'd4, 8'd2, 2'd0, 8'h00, 8'd3);
    tick(); tick();                 // CLEAR, RUN ch0
    cg_done = 1'b1;
    tick(); tick();                 // RUN, NEXT
    cg_done = 1'b0;
    tick();
    check("ab_clear_ch1", {24'b0, ch_idx}, 32'd1);
    check("ab_addr_ch1", {24'b0, cg_addr}, 32'h10);
    tick();
    check("ab_run_ch1", {31'b0, cg_en}, 32'd1);
    abort = 1'b1; cg_done = 1'b1;
    tick();
    abort = 1'b0; cg_done = 1'b0;
    check("ab_idle", {31'b0, busy}, 32'd0);
    check("ab_en_off", {31'b0, cg_en}, 32'd0);
    check("ab_no_done", {31'b0, done}, 32'd0);
    tick();
    check("ab_no_done_later", {31'b0, done}, 32'd0);
    run_pass(8'd4, 8'd2, 2'd0, 8'h00, 8'd1, 8'd3, 8'd1);

    // Abort beats start in IDLE: no pass and no error even for a bad config.
    i_size = 8'd5; k_size = 8'd3; stride_log2 = 2'd0; num_ch = 8'd0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("ab_idle_no_err", {31'b0, err}, 32'd0);
    check("ab_idle_no_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset in the middle of a pass.
    drive_start(8'd4, 8'd2, 2'd0, 8'h33, 8'd2);
    tick(); tick();
    check("rr_running", {31'b0, cg_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rr_busy", {31'b0, busy}, 32'd0);
    check("rr_en", {31'b0, cg_en}, 32'd0);
    check("rr_addr", {24'b0, cg_addr}, 32'd0);
    check("rr_osize", {24'b0, cg_o_size}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rr_no_done", {31'b0, done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
